uart_pack_assembler: RTL and testbench



---
 rtl/uart_pack_assembler_if.sv | 27 ++
 rtl/uart_pack_assembler.sv | 151 +++++++++++++++
 tb/tb_uart_pack_assembler.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pack_assembler_if.sv
// Byte-stream and packet-field bundle between the UART receiver/transmitter and the packet assembler.
// The master side feeds received bytes; the slave side returns fields, strobes and the TX reply.
interface uart_pack_assembler_if #(
    parameter int DATA_BIT = 32
) ();
    logic [7:0]          i_data;
    logic                i_rx_done_tick;
    logic [DATA_BIT-1:0] o_output_pattern;
    logic [DATA_BIT-1:0] o_freq_pattern;
    logic [7:0]          o_ctrl;
    logic                o_pack_valid;
    logic                o_tx_start;
    logic [7:0]          o_tx_data;
    logic                o_err_timeout;

    modport master (
        output i_data, i_rx_done_tick,
        input  o_output_pattern, o_freq_pattern, o_ctrl,
        input  o_pack_valid, o_tx_start, o_tx_data, o_err_timeout
    );

    modport slave (
        input  i_data, i_rx_done_tick,
        output o_output_pattern, o_freq_pattern, o_ctrl,
        output o_pack_valid, o_tx_start, o_tx_data, o_err_timeout
    );
endinterface

// File: rtl/uart_pack_assembler.sv
// Frames UART bytes into header/payload/checksum packets, latches validated fields and
// answers each packet with ACK or NAK; partial packets are dropped on inter-byte timeout.
module uart_pack_assembler #(
    parameter int         DATA_BIT    = 32,
    parameter logic [7:0] HEADER_BYTE = 8'hA5,
    parameter logic [7:0] ACK_BYTE    = 8'h06,
    parameter logic [7:0] NAK_BYTE    = 8'h15,
    parameter int         TIMEOUT_CLK = 100_000
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_pack_assembler_if.slave bus
);
    localparam int NB  = DATA_BIT / 8;
    localparam int PAY = 2 * NB + 1;
    localparam int CW  = $clog2(PAY + 1);
    localparam int TW  = $clog2(TIMEOUT_CLK);
    localparam logic [CW-1:0] LAST_IDX = CW'(PAY - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLK - 1);

    typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_CHECK} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       byte_cnt_q, byte_cnt_d;
    logic [7:0]          sum_q, sum_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic                stage_we;
    logic                accept;
    logic [PAY*8-1:0]    stage_flat;
    logic [DATA_BIT-1:0] pat_q, freq_q;
    logic [7:0]          ctrl_q;
    logic                valid_q, valid_d;
    logic                tx_start_q, tx_start_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                err_q, err_d;

    // One staging lane per payload byte, written when the byte counter points at it.
    genvar gi;
    generate
        for (gi = 0; gi < PAY; gi++) begin : g_stage
            logic [7:0] lane_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    lane_q <= 8'h00;
                end else if (stage_we && byte_cnt_q == CW'(gi)) begin
                    lane_q <= bus.i_data;
                end
            end
            assign stage_flat[gi*8 +: 8] = lane_q;
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        sum_d      = sum_q;
        tmo_d      = tmo_q;
        stage_we   = 1'b0;
        accept     = 1'b0;
        valid_d    = 1'b0;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        err_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                tmo_d = '0;
                if (bus.i_rx_done_tick && bus.i_data == HEADER_BYTE) begin
                    state_d    = S_PAYLOAD;
                    byte_cnt_d = '0;
                    sum_d      = 8'h00;
                end
            end
            S_PAYLOAD: begin
                if (bus.i_rx_done_tick) begin
                    stage_we   = 1'b1;
                    sum_d      = sum_q + bus.i_data;
                    tmo_d      = '0;
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    if (byte_cnt_q == LAST_IDX) begin
                        state_d = S_CHECK;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_IDLE;
                    tmo_d   = '0;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_CHECK: begin
                if (bus.i_rx_done_tick) begin
                    state_d    = S_IDLE;
                    tmo_d      = '0;
                    tx_start_d = 1'b1;
                    if (bus.i_data == sum_q) begin
                        accept    = 1'b1;
                        valid_d   = 1'b1;
                        tx_data_d = ACK_BYTE;
                    end else begin
                        tx_data_d = NAK_BYTE;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_IDLE;
                    tmo_d   = '0;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= '0;
            sum_q      <= 8'h00;
            tmo_q      <= '0;
            pat_q      <= '0;
            freq_q     <= '0;
            ctrl_q     <= 8'h00;
            valid_q    <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            sum_q      <= sum_d;
            tmo_q      <= tmo_d;
            valid_q    <= valid_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            err_q      <= err_d;
            if (accept) begin
                pat_q  <= stage_flat[DATA_BIT-1:0];
                freq_q <= stage_flat[2*DATA_BIT-1:DATA_BIT];
                ctrl_q <= stage_flat[PAY*8-1 -: 8];
            end
        end
    end

    assign bus.o_output_pattern = pat_q;
    assign bus.o_freq_pattern   = freq_q;
    assign bus.o_ctrl           = ctrl_q;
    assign bus.o_pack_valid     = valid_q;
    assign bus.o_tx_start       = tx_start_q;
    assign bus.o_tx_data        = tx_data_q;
    assign bus.o_err_timeout    = err_q;
endmodule

// File: tb/tb_uart_pack_assembler.sv
// Self-checking bench: byte stream with random gaps, corruption, timeouts and resets,
// compared every cycle against a queue-based packet model.
module tb_uart_pack_assembler;
    localparam int         DATA_BIT = 32;
    localparam int         NB       = DATA_BIT / 8;
    localparam int         PAY      = 2 * NB + 1;
    localparam int         T        = 16;
    localparam logic [7:0] HDR      = 8'hA5;
    localparam logic [7:0] ACK      = 8'h06;
    localparam logic [7:0] NAK      = 8'h15;

    logic clk;
    logic rst;

    uart_pack_assembler_if #(.DATA_BIT(DATA_BIT)) bus ();

    uart_pack_assembler #(
        .DATA_BIT    (DATA_BIT),
        .HEADER_BYTE (HDR),
        .ACK_BYTE    (ACK),
        .NAK_BYTE    (NAK),
        .TIMEOUT_CLK (T)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int last_tick = 0;
    int n_valid = 0;
    int n_tx = 0;
    int n_tmo = 0;
    int n_pkt = 0;
    byte unsigned frame[$];

    logic [DATA_BIT-1:0] exp_pat, exp_freq;
    logic [7:0]          exp_ctrl, exp_tx_data;
    logic                exp_valid, exp_tx_start, exp_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Packet-level reference: collect header+payload+checksum in a queue, judge on completion.
    task automatic model_edge(input logic tk, input logic [7:0] d, input logic r);
        logic [7:0] s;
        exp_valid    = 1'b0;
        exp_tx_start = 1'b0;
        exp_err      = 1'b0;
        if (r) begin
            frame.delete();
            exp_pat     = '0;
            exp_freq    = '0;
            exp_ctrl    = 8'h00;
            exp_tx_data = 8'h00;
        end else if (tk) begin
            last_tick = cyc;
            if (frame.size() != 0 || d == HDR) frame.push_back(d);
            if (frame.size() == PAY + 2) begin
                s = 8'h00;
                for (int k = 1; k <= PAY; k++) s = s + frame[k];
                exp_tx_start = 1'b1;
                n_pkt++;
                if (s == frame[PAY+1]) begin
                    exp_valid = 1'b1;
                    exp_tx_data = ACK;
                    for (int i = 0; i < NB; i++) begin
                        exp_pat[8*i +: 8]  = frame[1+i];
                        exp_freq[8*i +: 8] = frame[1+NB+i];
                    end
                    exp_ctrl = frame[1+2*NB];
                end else begin
                    exp_tx_data = NAK;
                end
                $display("packet %0d: sum %02h chk %02h -> reply %02h", n_pkt, s, frame[PAY+1], exp_tx_data);
                frame.delete();
            end
        end else if (frame.size() != 0 && (cyc - last_tick) == T) begin
            exp_err = 1'b1;
            $display("timeout at cycle %0d: dropped %0d bytes", cyc, frame.size());
            frame.delete();
        end
    endtask

    task automatic step(input logic tk, input logic [7:0] d, input logic r);
        bus.i_rx_done_tick = tk;
        bus.i_data         = d;
        rst                = r;
        @(posedge clk);
        model_edge(tk, d, r);
        #1;
        chk("pack_valid", 64'(bus.o_pack_valid), 64'(exp_valid));
        chk("tx_start", 64'(bus.o_tx_start), 64'(exp_tx_start));
        chk("tx_data", 64'(bus.o_tx_data), 64'(exp_tx_data));
        chk("err_timeout", 64'(bus.o_err_timeout), 64'(exp_err));
        chk("output_pattern", 64'(bus.o_output_pattern), 64'(exp_pat));
        chk("freq_pattern", 64'(bus.o_freq_pattern), 64'(exp_freq));
        chk("ctrl", 64'(bus.o_ctrl), 64'(exp_ctrl));
        if (bus.o_pack_valid === 1'b1) n_valid++;
        if (bus.o_tx_start === 1'b1) n_tx++;
        if (bus.o_err_timeout === 1'b1) n_tmo++;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), 1'b0);
    endtask

    task automatic send_byte(input logic [7:0] d, input int gap);
        step(1'b1, d, 1'b0);
        idle(gap - 1);
    endtask

    // Sends header and payload with the given gap, then the checksum tick with no trailing idle.
    task automatic send_frame(input logic [DATA_BIT-1:0] pat, input logic [DATA_BIT-1:0] freq,
                              input logic [7:0] ctrl, input logic [7:0] corrupt, input int gap);
        logic [7:0] p[PAY];
        logic [7:0] s;
        for (int i = 0; i < NB; i++) begin
            p[i]    = pat[8*i +: 8];
            p[NB+i] = freq[8*i +: 8];
        end
        p[2*NB] = ctrl;
        s = 8'h00;
        send_byte(HDR, gap);
        for (int i = 0; i < PAY; i++) begin
            s = s + p[i];
            send_byte(p[i], gap);
        end
        step(1'b1, s + corrupt, 1'b0);
    endtask

    initial begin
        int n0, t0, v0, gap;
        bus.i_rx_done_tick = 1'b0;
        bus.i_data         = 8'h00;
        rst                = 1'b1;
        exp_pat = '0; exp_freq = '0; exp_ctrl = 8'h00; exp_tx_data = 8'h00;
        exp_valid = 1'b0; exp_tx_start = 1'b0; exp_err = 1'b0;

        repeat (3) step(1'b0, 8'h00, 1'b1);
        chk("reset_pattern", 64'(bus.o_output_pattern), 64'd0);
        chk("reset_tx_data", 64'(bus.o_tx_data), 64'd0);
        idle(2);

        // Good frame: payload sum 0xC1
        send_frame(32'h12345678, 32'h11223344, 8'h03, 8'h00, 3);
        chk("good_valid", 64'(bus.o_pack_valid), 64'd1);
        chk("good_pattern", 64'(bus.o_output_pattern), 64'h12345678);
        chk("good_freq", 64'(bus.o_freq_pattern), 64'h11223344);
        chk("good_ctrl", 64'(bus.o_ctrl), 64'h03);
        chk("good_reply", 64'(bus.o_tx_data), 64'(ACK));
        idle(2);

        // Same frame, checksum off by one
        send_frame(32'h12345678, 32'h11223344, 8'h03, 8'h01, 3);
        chk("bad_valid", 64'(bus.o_pack_valid), 64'd0);
        chk("bad_tx_start", 64'(bus.o_tx_start), 64'd1);
        chk("bad_reply", 64'(bus.o_tx_data), 64'(NAK));
        chk("bad_pattern_held", 64'(bus.o_output_pattern), 64'h12345678);
        idle(2);

        // Leading garbage, header value inside the payload
        send_byte(8'h00, 3);
        send_byte(8'hFF, 3);
        send_frame(32'h12A55678, 32'h11223344, 8'h03, 8'h00, 3);
        chk("hdr_in_payload_valid", 64'(bus.o_pack_valid), 64'd1);
        chk("hdr_in_payload_pattern", 64'(bus.o_output_pattern), 64'h12A55678);
        idle(2);

        // Partial frame, then silence past the timeout
        n0 = n_tmo; t0 = n_tx;
        send_byte(HDR, 3);
        for (int i = 0; i < 4; i++) send_byte(8'(8'h10 + i), (i == 3) ? 1 : 3);
        idle(T + 2);
        chk("timeout_pulses", 64'(n_tmo - n0), 64'd1);
        chk("timeout_no_reply", 64'(n_tx - t0), 64'd0);
        send_frame(32'hDEADBEEF, 32'hCAFEF00D, 8'h5A, 8'h00, 2);
        chk("after_timeout_valid", 64'(bus.o_pack_valid), 64'd1);
        chk("after_timeout_pattern", 64'(bus.o_output_pattern), 64'hDEADBEEF);
        idle(2);

        // Every byte lands exactly on the expiry cycle
        n0 = n_tmo;
        send_frame(32'h0F1E2D3C, 32'h4B5A6978, 8'h87, 8'h00, T);
        chk("race_valid", 64'(bus.o_pack_valid), 64'd1);
        chk("race_no_timeout", 64'(n_tmo - n0), 64'd0);
        idle(2);

        // Reset after six bytes of a frame
        send_byte(HDR, 3);
        for (int i = 0; i < 5; i++) send_byte(8'(8'h21 * (i + 1)), 3);
        step(1'b0, 8'h00, 1'b1);
        chk("rst_pattern", 64'(bus.o_output_pattern), 64'd0);
        chk("rst_freq", 64'(bus.o_freq_pattern), 64'd0);
        chk("rst_ctrl", 64'(bus.o_ctrl), 64'd0);
        chk("rst_tx_data", 64'(bus.o_tx_data), 64'd0);
        v0 = n_valid;
        idle(2);
        send_frame(32'h0BADF00D, 32'h76543210, 8'hC3, 8'h00, 3);
        chk("post_rst_pattern", 64'(bus.o_output_pattern), 64'h0BADF00D);
        chk("post_rst_one_valid", 64'(n_valid - v0), 64'd1);
        idle(2);

        // Randomised traffic
        for (int f = 0; f < 150; f++) begin
            logic [7:0] p[PAY];
            logic [7:0] s;
            int rst_at, tmo_at;
            if ($urandom_range(0, 4) == 0) send_byte(8'($urandom), int'($urandom_range(2, 6)));
            for (int i = 0; i < PAY; i++) p[i] = 8'($urandom);
            if ($urandom_range(0, 3) == 0) p[$urandom_range(0, PAY - 1)] = HDR;
            rst_at = ($urandom_range(0, 29) == 0) ? int'($urandom_range(1, PAY)) : -1;
            tmo_at = ($urandom_range(0, 14) == 0) ? int'($urandom_range(0, PAY)) : -1;
            s = 8'h00;
            for (int i = 0; i < PAY; i++) s = s + p[i];
            if ($urandom_range(0, 4) == 0) s = s ^ 8'(1 << $urandom_range(0, 7));
            for (int i = 0; i <= PAY + 1; i++) begin
                logic [7:0] b;
                b = (i == 0) ? HDR : (i <= PAY) ? p[i-1] : s;
                if (i == rst_at) begin
                    step(1'b0, 8'h00, 1'b1);
                    step(1'b0, 8'h00, 1'b0);
                end
                gap = (i == tmo_at) ? int'($urandom_range(T + 1, T + 4)) : int'($urandom_range(2, T));
                send_byte(b, gap);
            end
            idle(int'($urandom_range(0, 3)));
        end
        idle(T + 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
